load: RTL and testbench
=======================

Name: load

Overview:
- Restore-side counterpart of the canvas save path.
- On request, reads the saved canvas from the 480-word x 640-bit RAM one row at a time and replays every pixel as a (x, y, colour, write-strobe) stream into the VGA drawing path.
- Row address = y. Bit x of a row word = pixel at column x (1 = drawn, 0 = background).
- Sits between the RAM read port and the same pixel-write mux the joystick drawer feeds.

Parameters:
- WIDTH, 640, pixels per row and bits per RAM word
- HEIGHT, 480, rows and RAM depth
- RD_LAT, 2, RAM read latency in cycles from read_addr change to valid q

Ports:
- CLOCK_50  input  1  system clock
- reset  input  1  synchronous, active-high reset
- load_sw  input  1  level request; a rising edge starts a restore, low aborts
- q  input  640  RAM read data for read_addr, valid RD_LAT cycles after read_addr is presented
- read_addr  output  9  RAM row address
- x  output  11  pixel column, 0..WIDTH-1
- y  output  11  pixel row, 0..HEIGHT-1
- pixel_color  output  1  pixel value, taken from bit x of the row word
- pixel_write  output  1  x, y and pixel_color are valid this cycle; the drawer writes them
- busy  output  1  restore in progress
- done  output  1  full frame replayed; held until load_sw goes low

Behaviour:
- Reset (sync, active-high) forces state IDLE. All outputs go to 0: read_addr, x, y, pixel_color, pixel_write, busy, done. The registered previous value of load_sw is also cleared to 0.
- A reset asserted mid-restore takes effect on the next clock edge. There is no partial output after that edge.
- The start condition is load_sw=1 while the registered previous value of load_sw is 0 (rising edge), evaluated only in IDLE.
- State IDLE: read_addr=0, busy=0. On the start condition go to FETCH.
- State FETCH: drive read_addr=row and load the wait counter with RD_LAT-1, then go to WAIT.
- State WAIT: decrement the wait counter. When it reaches 0, latch q into the row buffer (640b), set x=0, and go to SCAN.
  - Net effect: q is sampled exactly RD_LAT cycles after read_addr changes.
- State SCAN: each cycle drive pixel_write=1, y=row, pixel_color=rowbuf[x].
  - If x<WIDTH-1, increment x.
  - If x==WIDTH-1 and row<HEIGHT-1, increment row and go to FETCH.
  - If x==WIDTH-1 and row==HEIGHT-1, go to DONE.
  - Exactly WIDTH consecutive write cycles per row. pixel_write is 0 in FETCH and WAIT.
- State DONE: done=1, busy=0, pixel_write=0. When load_sw=0, go to IDLE and clear done.
- busy=1 in FETCH, WAIT and SCAN.
- Abort: load_sw=0 in FETCH, WAIT or SCAN moves to IDLE on that edge.
  - pixel_write is 0 from the next cycle and row resets to 0.
  - A later rising edge restarts from row 0.
- A held-high load_sw after DONE does not restart; it needs a low-then-high edge.
- Cycle cost per row = 1 (FETCH) + RD_LAT (WAIT) + WIDTH (SCAN). Default full frame = 480 x 643 = 308,640 cycles.
- Widths and wrap:
  - x and y are zero-extended to 11 bits. The row counter is 9 bits.
  - No wrap past HEIGHT-1 or WIDTH-1. The terminal compares above are exact.
- Outputs are registered. x, y, pixel_color and pixel_write change together on the same edge.
- RD_LAT must be at least 1. The RD_LAT=1 case goes FETCH -> WAIT -> SCAN with the latch happening in WAIT.

Test Plan:
- Reset during SCAN of row 5 -> next cycle all outputs 0, state IDLE. A new load_sw rise restarts at read_addr=0 and y=0.
- RAM model, RD_LAT=2, row 0 = bit 0 and bit 639 set, other rows 0; pulse load_sw high -> row 0 emits 640 writes:
  - x=0 colour 1, x=1..638 colour 0, x=639 colour 1
  - then exactly 3 non-write cycles, then row 1 starts with x=0, y=1.
- Full frame with a checkerboard pattern (bit = x^y) -> exactly 307,200 pixel_write cycles with every (x, y) visited once in raster order and colour = (x^y)&1. done rises after 308,640 cycles and busy falls the same cycle.
- Drop load_sw mid-row 100 at x=320 -> pixel_write=0 from the next cycle, busy=0, done=0. Re-raising load_sw restarts at y=0.
- Hold load_sw high after done -> no second pass, done stays 1. Drop it -> done=0. Raise it -> new pass.
- Sweep RD_LAT=1 and RD_LAT=3 -> row data always matches the addressed RAM word; inter-row gap = 1+RD_LAT cycles.

Source files
------------

// File: rtl/load.sv
// rtl/load.sv - replays a saved canvas from row RAM as a pixel write stream
module load #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int RD_LAT = 2
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             load_sw,
  input  logic [WIDTH-1:0] q,
  output logic [8:0]       read_addr,
  output logic [10:0]      x,
  output logic [10:0]      y,
  output logic             pixel_color,
  output logic             pixel_write,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SCAN, S_FINISH} state_t;

  localparam logic [10:0] X_LAST    = 11'(WIDTH - 1);
  localparam logic [8:0]  ROW_LAST  = 9'(HEIGHT - 1);
  localparam logic [7:0]  WAIT_INIT = 8'(RD_LAT - 1);

  state_t           state, state_n;
  logic             load_sw_q;
  logic [8:0]       row, row_n;
  logic [7:0]       wait_cnt, wait_cnt_n;
  // Row word is shifted right as the scan advances, so the next pixel is always bit 1.
  logic [WIDTH-1:0] rowbuf;
  logic             latch_row, shift_row;
  logic [8:0]       read_addr_n;
  logic [10:0]      x_n, y_n;
  logic             pixel_color_n, pixel_write_n, busy_n, done_n;

  // State, datapath and registered outputs; outputs are loaded with the values for the next state.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= S_IDLE;
      load_sw_q   <= 1'b0;
      row         <= '0;
      wait_cnt    <= '0;
      rowbuf      <= '0;
      read_addr   <= '0;
      x           <= '0;
      y           <= '0;
      pixel_color <= 1'b0;
      pixel_write <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      load_sw_q   <= load_sw;
      row         <= row_n;
      wait_cnt    <= wait_cnt_n;
      if (latch_row)
        rowbuf <= q;
      else if (shift_row)
        rowbuf <= rowbuf >> 1;
      read_addr   <= read_addr_n;
      x           <= x_n;
      y           <= y_n;
      pixel_color <= pixel_color_n;
      pixel_write <= pixel_write_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

  // Next-state: start on a load_sw rising edge, abort whenever load_sw drops.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (load_sw && !load_sw_q) state_n = S_FETCH;
      S_FETCH:  state_n = load_sw ? S_WAIT : S_IDLE;
      S_WAIT: begin
        if (!load_sw)
          state_n = S_IDLE;
        else if (wait_cnt == 8'd0)
          state_n = S_SCAN;
      end
      S_SCAN: begin
        if (!load_sw)
          state_n = S_IDLE;
        else if (x == X_LAST)
          state_n = (row == ROW_LAST) ? S_FINISH : S_FETCH;
      end
      S_FINISH: if (!load_sw) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Output and datapath next values; entering IDLE clears everything so an abort leaves no residue.
  always_comb begin
    row_n         = row;
    wait_cnt_n    = wait_cnt;
    latch_row     = 1'b0;
    shift_row     = 1'b0;
    read_addr_n   = read_addr;
    x_n           = x;
    y_n           = y;
    pixel_color_n = pixel_color;
    pixel_write_n = 1'b0;
    busy_n        = (state_n == S_FETCH) || (state_n == S_WAIT) || (state_n == S_SCAN);
    done_n        = (state_n == S_FINISH);
    case (state)
      S_FETCH: begin
        read_addr_n = row;
        wait_cnt_n  = WAIT_INIT;
      end
      S_WAIT: begin
        if (wait_cnt != 8'd0)
          wait_cnt_n = wait_cnt - 8'd1;
        if (state_n == S_SCAN) begin
          latch_row     = 1'b1;
          x_n           = '0;
          y_n           = {2'b00, row};
          pixel_color_n = q[0];
          pixel_write_n = 1'b1;
        end
      end
      S_SCAN: begin
        if (state_n == S_SCAN) begin
          shift_row     = 1'b1;
          x_n           = x + 11'd1;
          pixel_color_n = rowbuf[1];
          pixel_write_n = 1'b1;
        end else if (state_n == S_FETCH) begin
          row_n = row + 9'd1;
        end
      end
      default: ;
    endcase
    if (state_n == S_IDLE) begin
      row_n         = '0;
      read_addr_n   = '0;
      x_n           = '0;
      y_n           = '0;
      pixel_color_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_load.sv
// tb/tb_load.sv - self-checking bench for the canvas restore engine
`timescale 1ns/1ps
module tb_load;

  localparam int W  = 640;
  localparam int H  = 12;
  localparam int RD = 2;
  localparam int P  = W + 1 + RD;
  localparam int SW = 16;
  localparam int SH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          load_sw = 1'b0;
  logic [W-1:0]  q;
  logic [8:0]    read_addr;
  logic [10:0]   x, y;
  logic          pixel_color, pixel_write, busy, done;

  logic [W-1:0]  mem [0:511];
  logic [8:0]    addr_d1;
  always @(posedge clk) addr_d1 <= read_addr;
  assign q = mem[addr_d1];

  load #(.WIDTH(W), .HEIGHT(H), .RD_LAT(RD)) dut (
    .CLOCK_50(clk), .reset(reset), .load_sw(load_sw), .q(q), .read_addr(read_addr),
    .x(x), .y(y), .pixel_color(pixel_color), .pixel_write(pixel_write), .busy(busy), .done(done)
  );

  logic [SW-1:0] mem_s [0:511];
  logic          load_s = 1'b0;
  logic [SW-1:0] q_s1, q_s3;
  logic [8:0]    ra_s1, ra_s3, ra_s3_d1, ra_s3_d2;
  logic [10:0]   x_s [2];
  logic [10:0]   y_s [2];
  logic          col_s [2];
  logic          pw_s [2];
  logic          busy_s [2];
  logic          done_s [2];
  always @(posedge clk) begin
    ra_s3_d1 <= ra_s3;
    ra_s3_d2 <= ra_s3_d1;
  end
  assign q_s1 = mem_s[ra_s1];
  assign q_s3 = mem_s[ra_s3_d2];

  load #(.WIDTH(SW), .HEIGHT(SH), .RD_LAT(1)) dut_l1 (
    .CLOCK_50(clk), .reset(reset), .load_sw(load_s), .q(q_s1), .read_addr(ra_s1),
    .x(x_s[0]), .y(y_s[0]), .pixel_color(col_s[0]), .pixel_write(pw_s[0]), .busy(busy_s[0]), .done(done_s[0])
  );
  load #(.WIDTH(SW), .HEIGHT(SH), .RD_LAT(3)) dut_l3 (
    .CLOCK_50(clk), .reset(reset), .load_sw(load_s), .q(q_s3), .read_addr(ra_s3),
    .x(x_s[1]), .y(y_s[1]), .pixel_color(col_s[1]), .pixel_write(pw_s[1]), .busy(busy_s[1]), .done(done_s[1])
  );

  typedef struct packed {
    logic        pw;
    logic [10:0] x;
    logic [10:0] y;
    logic        col;
    logic        busy;
    logic        done;
  } smp_t;

  smp_t trace[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  // Reference: cycle c after the start edge lies in row c/P; the first 1+RD cycles of a row are silent.
  function automatic smp_t expect_main(int c);
    smp_t e;
    int   r, k;
    e = '0;
    if (c < H * P) begin
      r = c / P;
      k = c % P;
      e.busy = 1'b1;
      if (k >= 1 + RD) begin
        e.pw  = 1'b1;
        e.x   = 11'(k - 1 - RD);
        e.y   = 11'(r);
        e.col = mem[r][k - 1 - RD];
      end
    end else begin
      e.done = 1'b1;
    end
    return e;
  endfunction

  function automatic int model_diff(int n);
    smp_t e, a;
    for (int c = 0; c < n; c++) begin
      e = expect_main(c);
      a = trace[c];
      if (a.pw !== e.pw || a.busy !== e.busy || a.done !== e.done) return c;
      if (e.pw && (a.x !== e.x || a.y !== e.y || a.col !== e.col)) return c;
    end
    return -1;
  endfunction

  task automatic collect(int n);
    smp_t s;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s.pw = pixel_write; s.x = x; s.y = y; s.col = pixel_color; s.busy = busy; s.done = done;
      trace.push_back(s);
    end
  endtask

  task automatic start_pass();
    trace.delete();
    load_sw = 1'b1;
  endtask

  task automatic stop_pass();
    load_sw = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++)
      for (int j = 0; j < W / 32; j++)
        mem[r][j*32 +: 32] = $urandom();
  endtask

  task automatic test_reset();
    reset = 1'b1; load_sw = 1'b0; load_s = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({read_addr, x, y, pixel_color, pixel_write, busy, done} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got ra=%0d x=%0d y=%0d c=%b w=%b b=%b d=%b, want all 0",
               read_addr, x, y, pixel_color, pixel_write, busy, done);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    tests_run++;
    if ({pixel_write, busy, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL idle_quiet: got w=%b b=%b d=%b, want 000", pixel_write, busy, done);
    end
  endtask

  task automatic test_row0();
    int d, nw, last_w, next_w;
    for (int r = 0; r < H; r++) mem[r] = '0;
    mem[0][0] = 1'b1;
    mem[0][W-1] = 1'b1;
    start_pass();
    collect(P + RD + 2);
    d = model_diff(P + RD + 2);
    tests_run++;
    if (d != -1) begin
      tests_failed++;
      $display("FAIL row0_stream: cycle %0d got w=%b x=%0d y=%0d c=%b, want model", d,
               trace[d].pw, trace[d].x, trace[d].y, trace[d].col);
    end
    nw = 0; last_w = -1; next_w = -1;
    for (int c = 0; c < P; c++) if (trace[c].pw === 1'b1) begin nw++; last_w = c; end
    for (int c = P + RD + 1; c >= P; c--) if (trace[c].pw === 1'b1) next_w = c;
    tests_run++;
    if (nw != W) begin
      tests_failed++;
      $display("FAIL row0_count: got %0d writes, want %0d", nw, W);
    end
    tests_run++;
    if (next_w - last_w - 1 != 1 + RD) begin
      tests_failed++;
      $display("FAIL row_gap: got %0d idle cycles, want %0d", next_w - last_w - 1, 1 + RD);
    end
    stop_pass();
  endtask

  task automatic test_reset_mid();
    int d;
    fill_random();
    start_pass();
    collect(5 * P + 3 + 10);
    reset = 1'b1;
    load_sw = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({read_addr, x, y, pixel_color, pixel_write, busy, done} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid: got ra=%0d x=%0d y=%0d w=%b b=%b, want all 0",
               read_addr, x, y, pixel_write, busy);
    end
    reset = 1'b0;
    @(negedge clk);
    start_pass();
    collect(4);
    d = model_diff(4);
    tests_run++;
    if (d != -1 || read_addr !== 9'd0) begin
      tests_failed++;
      $display("FAIL reset_restart: diff at %0d ra=%0d, want no diff ra=0", d, read_addr);
    end
    stop_pass();
  endtask

  task automatic test_frame();
    int d, nw, rise;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        mem[r][c] = 1'((c ^ r) & 1);
    start_pass();
    collect(H * P + 3);
    d = model_diff(H * P + 3);
    tests_run++;
    if (d != -1) begin
      tests_failed++;
      $display("FAIL frame_stream: cycle %0d got w=%b x=%0d y=%0d c=%b, want model", d,
               trace[d].pw, trace[d].x, trace[d].y, trace[d].col);
    end
    nw = 0; rise = -1;
    for (int c = 0; c < H * P + 3; c++) begin
      if (trace[c].pw === 1'b1) nw++;
      if (rise < 0 && trace[c].done === 1'b1) rise = c;
    end
    tests_run++;
    if (nw != H * W) begin
      tests_failed++;
      $display("FAIL frame_count: got %0d writes, want %0d", nw, H * W);
    end
    tests_run++;
    if (rise != H * P || trace[H*P].busy !== 1'b0 || trace[H*P-1].busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL done_timing: done rose at %0d, want %0d with busy falling together", rise, H * P);
    end
    stop_pass();
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_clear: got done=%b, want 0", done);
    end
  endtask

  task automatic test_abort();
    int d;
    fill_random();
    start_pass();
    collect(5 * P + 3 + 321);
    tests_run++;
    if (trace[$].x !== 11'd320 || trace[$].y !== 11'd5 || trace[$].pw !== 1'b1 || model_diff(trace.size()) != -1) begin
      tests_failed++;
      $display("FAIL abort_position: got x=%0d y=%0d w=%b, want x=320 y=5 w=1", trace[$].x, trace[$].y, trace[$].pw);
    end
    load_sw = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({pixel_write, busy, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL abort_stop: got w=%b b=%b d=%b, want 000", pixel_write, busy, done);
    end
    @(negedge clk);
    start_pass();
    collect(P + 4);
    d = model_diff(P + 4);
    tests_run++;
    if (d != -1) begin
      tests_failed++;
      $display("FAIL abort_restart: cycle %0d got x=%0d y=%0d w=%b, want model from row 0", d,
               trace[d].x, trace[d].y, trace[d].pw);
    end
    stop_pass();
  endtask

  task automatic test_done_hold();
    int d;
    fill_random();
    start_pass();
    collect(H * P + 50);
    d = model_diff(H * P + 50);
    tests_run++;
    if (d != -1) begin
      tests_failed++;
      $display("FAIL hold_stream: cycle %0d got w=%b b=%b d=%b, want model", d,
               trace[d].pw, trace[d].busy, trace[d].done);
    end
    load_sw = 1'b0;
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_drop: got done=%b busy=%b, want 0 0", done, busy);
    end
    start_pass();
    collect(P + 4);
    d = model_diff(P + 4);
    tests_run++;
    if (d != -1) begin
      tests_failed++;
      $display("FAIL hold_new_pass: cycle %0d got w=%b x=%0d y=%0d, want model", d,
               trace[d].pw, trace[d].x, trace[d].y);
    end
    stop_pass();
  endtask

  task automatic test_rd_lat();
    int  err [2];
    int  first [2];
    int  nw [2];
    int  rd, p, r, k;
    logic e_pw, e_busy, e_done, ok;
    for (int r2 = 0; r2 < SH; r2++) mem_s[r2] = 16'($urandom());
    for (int i = 0; i < 2; i++) begin err[i] = 0; first[i] = -1; nw[i] = 0; end
    load_s = 1'b1;
    for (int c = 0; c < SH * (SW + 4) + 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        rd = (i == 0) ? 1 : 3;
        p  = SW + 1 + rd;
        e_pw = 1'b0; e_busy = 1'b0; e_done = 1'b0; r = 0; k = 0;
        if (c < SH * p) begin
          r = c / p; k = c % p; e_busy = 1'b1;
          e_pw = (k >= 1 + rd);
        end else begin
          e_done = 1'b1;
        end
        ok = (pw_s[i] === e_pw) && (busy_s[i] === e_busy) && (done_s[i] === e_done);
        if (e_pw) begin
          if (x_s[i] !== 11'(k - 1 - rd) || y_s[i] !== 11'(r) || col_s[i] !== mem_s[r][k - 1 - rd]) ok = 1'b0;
        end
        if (pw_s[i] === 1'b1) nw[i]++;
        if (!ok) begin
          err[i]++;
          if (first[i] < 0) first[i] = c;
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (err[i] != 0) begin
        tests_failed++;
        $display("FAIL rdlat%0d_stream: %0d bad cycles, first at %0d, want 0", (i == 0) ? 1 : 3, err[i], first[i]);
      end
      tests_run++;
      if (nw[i] != SH * SW) begin
        tests_failed++;
        $display("FAIL rdlat%0d_count: got %0d writes, want %0d", (i == 0) ? 1 : 3, nw[i], SH * SW);
      end
    end
    load_s = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_row0();
    test_reset_mid();
    test_frame();
    test_abort();
    test_done_hold();
    test_rd_lat();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
